// File: rtl/v_instr_queue.sv
// v_instr_queue
// Issue queue between the scalar core and the vector coprocessor.
// OP-V instructions (opcode 7'b1010111) are buffered in a DEPTH-entry FIFO.
// Any other handshaken instruction is dropped, and a one-cycle `illegal`
// pulse is raised for it.
// Config instructions (funct3 = 3'b111) act as issue barriers: they wait for
// !cop_busy, and after they pop they force one idle issue cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr    push side (scalar core)
//   out_valid/out_ready/out_instr issue side (coprocessor op_instr_base)
//   cop_busy          coprocessor has an instruction in flight
//   flush             synchronous clear of all queued entries
//   illegal           registered pulse for a dropped non-OP-V instruction
//   count             number of valid entries
//   cfg_pending       config head held back by the barrier
module v_instr_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_instr,
  input  logic                     out_ready,
  input  logic                     cop_busy,
  input  logic                     flush,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     cfg_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] OPC_OPV  = 7'b1010111;
  localparam logic [2:0] F3_CFG   = 3'b111;

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_gap;
  logic            r_illegal;

  logic [XLEN-1:0] w_head;
  logic            w_head_cfg;
  logic            w_nonempty;
  logic            w_in_fire;
  logic            w_in_opv;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_cfg = (w_head[6:0] == OPC_OPV) && (w_head[14:12] == F3_CFG);
  assign w_nonempty = (r_count != '0);

  // Full is decided by count alone; a pop in the same cycle does not free a slot.
  assign in_ready   = (r_count != CW'(DEPTH));
  assign w_in_fire  = in_valid && in_ready;
  assign w_in_opv   = (in_instr[6:0] == OPC_OPV);
  assign w_push     = w_in_fire && w_in_opv;
  assign w_drop     = w_in_fire && !w_in_opv;

  // The barrier depends on cop_busy combinationally, so a stalled config head
  // issues in the same cycle that cop_busy drops.
  assign out_valid   = w_nonempty && !r_gap && !(w_head_cfg && cop_busy);
  assign out_instr   = out_valid ? w_head : '0;
  assign w_pop       = out_valid && out_ready;

  assign cfg_pending = w_nonempty && w_head_cfg && (cop_busy || r_gap);
  assign count       = r_count;
  assign illegal     = r_illegal;

  // Storage has no reset; its contents are qualified by count.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_gap     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      // The illegal pulse is tracked independently of flush.
      r_illegal <= w_drop;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_gap    <= 1'b0;
      end else begin
        r_gap <= w_pop && w_head_cfg;
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_v_instr_queue.sv
// Self-checking bench for v_instr_queue (DEPTH=4, XLEN=32).
// A scoreboard queue holds the expected FIFO contents; every cycle the outputs
// are compared against a behavioural model of the queue. Directed constant
// checks cover the scenarios called out for this block.
module tb_v_instr_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;
  logic            cop_busy;
  logic            flush;
  logic            illegal;
  logic [2:0]      count;
  logic            cfg_pending;

  v_instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .cop_busy    (cop_busy),
    .flush       (flush),
    .illegal     (illegal),
    .count       (count),
    .cfg_pending (cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference state
  logic [31:0] exp_q[$];
  int          m_count   = 0;
  logic        m_gap     = 1'b0;
  logic        m_ill     = 1'b0;
  logic        last_push = 1'b0;

  function automatic logic is_opv(input logic [31:0] ins);
    return ins[6:0] == 7'b1010111;
  endfunction

  function automatic logic is_cfg(input logic [31:0] ins);
    return is_opv(ins) && (ins[14:12] == 3'b111);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare all outputs against the model, then advance the
  // model with the handshakes that the current inputs imply. The task is
  // entered 1 time unit after a rising edge and returns at the same point of
  // the next cycle.
  task automatic cyc();
    logic [31:0] head;
    logic        hcfg, ev, pop, push, drop;
    #1;
    head = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    hcfg = is_cfg(head);
    ev   = (m_count != 0) && !m_gap && !(hcfg && cop_busy);
    chk("in_ready",    {31'b0, in_ready},    {31'b0, m_count != DEPTH});
    chk("out_valid",   {31'b0, out_valid},   {31'b0, ev});
    chk("out_instr",   out_instr,            ev ? head : 32'h0);
    chk("count",       {29'b0, count},       32'(m_count));
    chk("cfg_pending", {31'b0, cfg_pending},
        {31'b0, (m_count != 0) && hcfg && (cop_busy || m_gap)});
    chk("illegal",     {31'b0, illegal},     {31'b0, m_ill});
    pop  = ev && out_ready;
    push = in_valid && (m_count != DEPTH) && is_opv(in_instr);
    drop = in_valid && (m_count != DEPTH) && !is_opv(in_instr);
    @(posedge clk);
    m_ill = drop;
    last_push = push && !flush;
    if (flush) begin
      exp_q.delete();
      m_gap = 1'b0;
    end else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(in_instr);
      m_gap = pop && hcfg;
    end
    m_count = exp_q.size();
    #1;
  endtask

  localparam logic [31:0] VSETVLI = 32'h00207057;
  localparam logic [31:0] VMV     = 32'h5C004457;
  localparam logic [31:0] ADDI    = 32'h00000013;

  logic [31:0] fill [5];

  initial begin
    fill[0] = 32'h5C004457; fill[1] = 32'h38406657; fill[2] = 32'h38004857;
    fill[3] = 32'h3C406A57; fill[4] = 32'h3C004C57;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    cop_busy = 1'b0; flush = 1'b0;

    // Reset values
    #3;
    chk("rst_in_ready",    {31'b0, in_ready},    32'd1);
    chk("rst_out_valid",   {31'b0, out_valid},   32'd0);
    chk("rst_out_instr",   out_instr,            32'd0);
    chk("rst_illegal",     {31'b0, illegal},     32'd0);
    chk("rst_count",       {29'b0, count},       32'd0);
    chk("rst_cfg_pending", {31'b0, cfg_pending}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single issue of a config instruction, then the one-cycle gap
    out_ready = 1'b1; in_valid = 1'b1; in_instr = VSETVLI;
    cyc();
    chk("single_valid", {31'b0, out_valid}, 32'd1);
    chk("single_instr", out_instr, VSETVLI);
    in_instr = VMV;
    cyc();
    in_valid = 1'b0;
    chk("gap_valid", {31'b0, out_valid}, 32'd0);
    chk("gap_count", {29'b0, count}, 32'd1);
    cyc();
    chk("after_gap_instr", out_instr, VMV);
    cyc();
    chk("single_count0", {29'b0, count}, 32'd0);

    // Order and full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = fill[i];
      cyc();
    end
    in_instr = fill[4]; out_ready = 1'b1;
    chk("full_count",    {29'b0, count},    32'd4);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (last_push) in_valid = 1'b0;
    end
    chk("full_drained", {29'b0, count}, 32'd0);

    // Barrier
    out_ready = 1'b0; cop_busy = 1'b1;
    in_valid = 1'b1; in_instr = VMV;     cyc();
    in_instr = VSETVLI;                  cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("barrier_pending", {31'b0, cfg_pending}, 32'd1);
    chk("barrier_valid",   {31'b0, out_valid},   32'd0);
    cyc();
    cop_busy = 1'b0;
    #1;
    chk("barrier_release_valid", {31'b0, out_valid}, 32'd1);
    chk("barrier_release_instr", out_instr, VSETVLI);
    cyc();
    cyc();

    // Illegal instruction
    in_valid = 1'b1; in_instr = ADDI;
    cyc();
    in_valid = 1'b0;
    chk("illegal_pulse", {31'b0, illegal},   32'd1);
    chk("illegal_count", {29'b0, count},     32'd0);
    chk("illegal_noiss", {31'b0, out_valid}, 32'd0);
    cyc();
    chk("illegal_one_cycle", {31'b0, illegal}, 32'd0);

    // Continuous stream across pointer wrap
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_instr = 32'h02000057 | (32'(i + 1) << 20);
      cyc();
      if (i > 0) chk("stream_count", {29'b0, count}, 32'd1);
    end
    in_valid = 1'b0;
    cyc();
    cyc();

    // Flush with a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = fill[i];
      cyc();
    end
    flush = 1'b1; in_instr = fill[3];
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", {29'b0, count},     32'd0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    cyc();

    // Reset mid-stream
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = fill[i + 1];
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", {29'b0, count}, 32'd2);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_out_instr", out_instr,          32'd0);
    chk("arst_count",     {29'b0, count},     32'd0);
    exp_q.delete(); m_count = 0; m_gap = 1'b0; m_ill = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = fill[2];
    cyc();
    in_valid = 1'b0;
    chk("post_rst_instr", out_instr, fill[2]);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/v_instr_queue.md
# v_instr_queue

Instruction issue queue between the scalar core and the integrated vector coprocessor. It buffers OP-V instructions (opcode 7'b1010111) in a small FIFO and drops anything else with an `illegal` pulse. It presents one instruction at a time on the coprocessor's `op_instr_base` input through a valid/ready handshake. Configuration instructions (funct3 = 3'b111) act as issue barriers, so a new vl/vsew/vlmul setting never overlaps an in-flight vector operation.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `XLEN`, 32: instruction width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  scalar core offers `in_instr`.
- `in_instr`  in  XLEN  instruction from the scalar core.
- `in_ready`  out  1  queue can accept; equals `count != DEPTH`.
- `out_valid`  out  1  `out_instr` is issuable this cycle.
- `out_instr`  out  XLEN  head instruction; drives coprocessor `op_instr_base`; 0 when `out_valid` = 0.
- `out_ready`  in  1  coprocessor accepts `out_instr` this cycle.
- `cop_busy`  in  1  coprocessor has an instruction in flight.
- `flush`  in  1  synchronous clear of all queued instructions.
- `illegal`  out  1  one-cycle pulse: a non-OP-V instruction was handshaken and discarded.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `cfg_pending`  out  1  the head entry is a config instruction waiting on the barrier.

## Operation
- **Push:** happens when `in_valid && in_ready && in_instr[6:0] == 7'b1010111`. The instruction is written at `wr_ptr`, `wr_ptr` increments modulo DEPTH, and `count` increments.
- **Illegal:** `in_valid && in_ready` with any other opcode writes nothing and leaves `count` unchanged. `illegal` is a registered pulse that goes high the next cycle for exactly one cycle.
- **Head classification:** `head_cfg = (head[6:0] == 7'b1010111) && (head[14:12] == 3'b111)`.
- **Issue condition:** `out_valid = (count != 0) && !gap && !(head_cfg && cop_busy)`.
- **Pop:** happens when `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH and `count` decrements.
- **Config gap:** when a config instruction pops, the 1-bit register `gap` is set for exactly one cycle. This holds `out_valid` low so the CSR update settles before the next issue.
- **Non-config heads** issue regardless of `cop_busy`; the coprocessor applies backpressure through `out_ready`.
- **`cfg_pending`:** `(count != 0) && head_cfg && (cop_busy || gap)`.
- **Simultaneous push and pop** in the same cycle: `count` is unchanged and both pointers advance.
- **Full:** `in_ready` = 0 even if a pop occurs that cycle. There is no full-bypass.
- **Empty:** there is no push-to-output bypass. An instruction is visible only after it is written.
- **Wrap-around:** both pointers are `$clog2(DEPTH)` bits wide and wrap naturally. Full and empty are determined by `count`, not by pointer comparison.
- **Flush:**
  - Next edge: `count`, `wr_ptr`, `rd_ptr` and `gap` go to 0. The `illegal` pulse register is unaffected.
  - Flush has priority over a push or pop in the same cycle; both are ignored.
  - An `out_valid && out_ready` handshake in the flush cycle still counts as issued to the coprocessor. The queue does not recall it.

## Timing
- **Reset values:** `in_ready` = 1, `out_valid` = 0, `out_instr` = 0, `illegal` = 0, `count` = 0, `cfg_pending` = 0. Pointers and `gap` are 0. Storage contents are don't-care.
- **Reset mid-operation:** all queued instructions are lost. Outputs take their reset values immediately, asynchronously.
- **Latency:** an instruction pushed at edge N has `out_valid` = 1 during cycle N+1, given no barrier. `out_instr` is driven combinationally from the registered head.
- **Throughput:** one instruction per cycle for non-config instructions. Each config instruction costs at least one idle issue cycle.
- **Handshakes:** `in_*` and `out_*` transfer on the edge where valid && ready. `out_valid` never depends combinationally on `out_ready`. `in_ready` never depends on `in_valid`.
- **Barrier stall:** a config head with `cop_busy` = 1 stalls until the first cycle `cop_busy` = 0. `out_valid` rises in that same cycle, combinationally from `cop_busy`.

## Test plan
- **Reset and single issue:** after reset, push 32'h00207057 (vsetvli) with `cop_busy` = 0 and `out_ready` = 1.
  - Expect `out_valid` = 1 and `out_instr` = 32'h00207057 one cycle after the push.
  - Expect `count` to return to 0 and a one-cycle gap before the next issue.
- **Order and full:** push 32'h5C004457, 32'h38406657, 32'h38004857, 32'h3C406A57 with `out_ready` = 0.
  - Expect `count` = 4 and `in_ready` = 0; a 5th push of 32'h3C004C57 is not accepted.
  - Raise `out_ready`: expect the four issue in order on consecutive cycles, then the 5th once it is accepted.
- **Barrier:** queue 32'h5C004457 then 32'h00207057, holding `cop_busy` = 1.
  - The vmv issues; then `cfg_pending` = 1 and `out_valid` = 0.
  - Drop `cop_busy`: the config issues in that cycle, followed by one idle cycle.
- **Illegal:** push 32'h00000013 (addi).
  - Expect `illegal` high for exactly one cycle, `count` unchanged, nothing issued.
- **Wrap and simultaneous push/pop:** stream 10 OP-V instructions with `in_valid` = `out_ready` = 1 continuously.
  - Expect `count` to stay at 1 after the first push, with outputs in order across pointer wrap.
- **Flush and reset mid-stream:** with 3 entries queued, assert `flush` together with `in_valid`.
  - Expect `count` = 0 next cycle and the pushed instruction discarded.
  - Separately, assert `rst` with 2 entries queued: expect immediate `out_valid` = 0, `out_instr` = 0, `count` = 0.
